level_monitor: RTL and testbench
================================

Name: level_monitor

Overview:
Clocked, parametrised level-indicator for a tank with N_LEVELS thermometer-coded level switches. Each switch input is synchronised and debounced, and the debounced levels are counted. The block drives a hysteretic alarm (Red/Green), an active-low seven-segment digit and a binary level count. Non-thermometer switch patterns are detected as a sensor fault, shown as a blinking Red and an "F" digit. It replaces the combinational indicator as the board's top-level level-monitoring block.

Parameters:
N_LEVELS, 6, number of level switches; legal 1..9.
DEB_CYCLES, 4, consecutive stable cycles required before a debounced bit changes; legal >=1.
HI_THRESH, 6, level at or above which ALARM is entered; legal LO_THRESH < HI_THRESH <= N_LEVELS.
LO_THRESH, 4, level at or below which ALARM is left; legal >=0.
BLINK_DIV, 25000000, clock cycles per half-period of the fault blink (0.5 s at 50 MHz); legal >=1.

Ports:
Clk  input  1  system clock, rising edge.
Rst_n  input  1  asynchronous, active-low reset.
Sw  input  N_LEVELS  raw level switches; bit0 = lowest level; asynchronous to Clk.
Red  output  1  alarm lamp: on in ALARM, blinking in FAULT.
Green  output  1  normal lamp: on only in NORMAL.
Segments  output  7  active-low digit; bit0=a ... bit6=g.
Level  output  4  registered count of debounced set switches, 0..N_LEVELS.
Fault  output  1  high while in FAULT.

Behaviour:
- Reset: Rst_n low clears all flops immediately, with no clock edge needed.
  - Reset state: sync and debounced vectors 0, debounce counters 0, blink counter 0, blink bit 0, state NORMAL.
  - Reset outputs: Red=0, Green=1, Level=0, Fault=0, Segments=7'b1000000 ("0").
- Synchroniser: two flops per bit (sync1, sync2).
- Debounce, per bit:
  - If sync2 == deb: counter <= 0.
  - Else if counter == DEB_CYCLES-1: deb <= sync2, counter <= 0.
  - Else: counter += 1.
  - Any return of sync2 to deb before the limit restarts the count.
- Level/fault register, updated every cycle from deb:
  - Level <= popcount(deb), 4 bits, no overflow possible.
  - flt <= 1 if deb is not of the form 0..01..1 from bit0 (all-zero counts as valid).
- State machine (NORMAL, ALARM, FAULT), evaluated on registered Level/flt. Priority: fault first.
  - Any state, flt=1 -> FAULT.
  - NORMAL: Level >= HI_THRESH -> ALARM; otherwise stay.
  - ALARM: Level <= LO_THRESH -> NORMAL; LO_THRESH < Level < HI_THRESH -> stay (hysteresis).
  - FAULT: flt=0 -> ALARM if Level >= HI_THRESH, else NORMAL. No memory of the pre-fault state.
- Outputs, registered with the state:
  - NORMAL: Red=0, Green=1.
  - ALARM: Red=1, Green=0.
  - FAULT: Red=blink, Green=0, Fault=1.
- Segments:
  - Non-FAULT: active-low decode of Level. 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - FAULT: 0001110 ("F").
- Blink: a free-running counter 0..BLINK_DIV-1; the blink bit toggles on each wrap. Phase at FAULT entry is arbitrary.
- Latency: an Sw change held stable reaches Red/Green/Segments/Level/Fault exactly 4+DEB_CYCLES rising edges later.
  - Sync: 2 edges.
  - Debounce: DEB_CYCLES edges.
  - Level register: 1 edge.
  - State/output register: 1 edge.
- Boundaries:
  - A pulse shorter than DEB_CYCLES cycles after sync produces no output change.
  - Several bits changing in the same cycle debounce independently; transient non-thermometer patterns during settling raise FAULT if they last one cycle in deb.
  - Level == HI_THRESH == N_LEVELS is valid.

Test Plan (N_LEVELS=6, DEB_CYCLES=4, HI_THRESH=6, LO_THRESH=4, BLINK_DIV=8):
1. Hold Rst_n=0 with no clock, Sw=6'b111111 -> Red=0, Green=1, Level=0, Fault=0, Segments=7'b1000000.
2. After reset, Sw=6'b111111 held -> exactly 8 edges later Red=1, Green=0, Level=6, Segments=7'b0000010; unchanged at edge 7.
3. From ALARM: Sw=6'b011111 -> Level=5, Segments=7'b0010010, Red stays 1. Then Sw=6'b001111 -> Level=4, Red=0, Green=1, Segments=7'b0011001.
4. From Sw=0, pulse Sw=6'b000001 for 3 cycles, then 0 -> Level, Red, Green and Segments never change over 20 cycles.
5. Sw=6'b000101 -> Fault=1, Green=0, Segments=7'b0001110, Red toggles every 8 cycles. Then Sw=6'b000111 -> Fault=0, Green=1, Level=3, Segments=7'b0110000.
6. In ALARM, drop Rst_n mid-cycle -> Red=0, Green=1, Level=0, Segments=7'b1000000 before the next Clk edge. Release with Sw=6'b111111 -> ALARM again 8 edges after the first post-release edge.

Source files
------------

// File: rtl/level_monitor.sv
// Tank level monitor: synchronises and debounces thermometer-coded level
// switches, counts the settled levels and drives a hysteretic Red/Green
// alarm, an active-low seven-segment digit and a binary level count.
// Switch patterns that are not a solid run of ones from bit0 are reported
// as a sensor fault: blinking Red and an "F" on the digit.
module level_monitor #(
  parameter int N_LEVELS   = 6,
  parameter int DEB_CYCLES = 4,
  parameter int HI_THRESH  = 6,
  parameter int LO_THRESH  = 4,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [N_LEVELS-1:0] Sw,
  output logic                Red,
  output logic                Green,
  output logic [6:0]          Segments,
  output logic [3:0]          Level,
  output logic                Fault
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0]       DEB_LAST   = CW'(DEB_CYCLES - 1);
  localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [3:0]          HI_LEVEL   = 4'(HI_THRESH);
  localparam logic [3:0]          LO_LEVEL   = 4'(LO_THRESH);
  localparam logic [N_LEVELS-1:0] SW_ONE     = N_LEVELS'(1);

  localparam logic [6:0] SEG_F = 7'b0001110;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    ALARM  = 2'd1,
    FAULT  = 2'd2
  } stateT;

  logic [N_LEVELS-1:0] sync1, sync2, deb;
  logic [CW-1:0]       debCnt [N_LEVELS];
  logic [3:0]          levelNext, levelReg;
  logic                fltNext, flt;
  logic [BW-1:0]       blinkCnt;
  logic                blinkBit;
  stateT               state, stateNext;
  logic                redNext, greenNext, faultNext;
  logic [6:0]          segNext;

  // Active-low seven-segment pattern for a digit 0..9.
  function automatic logic [6:0] segDecode(input logic [3:0] value);
    case (value)
      4'd0:    segDecode = 7'b1000000;
      4'd1:    segDecode = 7'b1111001;
      4'd2:    segDecode = 7'b0100100;
      4'd3:    segDecode = 7'b0110000;
      4'd4:    segDecode = 7'b0011001;
      4'd5:    segDecode = 7'b0010010;
      4'd6:    segDecode = 7'b0000010;
      4'd7:    segDecode = 7'b1111000;
      4'd8:    segDecode = 7'b0000000;
      4'd9:    segDecode = 7'b0010000;
      default: segDecode = 7'b1111111;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      // NOTE: non-blocking, so sync2 takes the previous sync1 and the chain really is two flops deep.
      sync1 <= Sw;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: a bit only follows sync2 after DEB_CYCLES consecutive differing cycles.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      deb <= '0;
      // NOTE: the counter array is real state, so every element is cleared explicitly in reset.
      for (int i = 0; i < N_LEVELS; i++) debCnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_LEVELS; i++) begin
        if (sync2[i] == deb[i]) begin
          debCnt[i] <= '0;
        end else if (debCnt[i] == DEB_LAST) begin
          deb[i]    <= sync2[i];
          debCnt[i] <= '0;
        end else begin
          debCnt[i] <= debCnt[i] + CW'(1);
        end
      end
    end
  end

  // Popcount of the settled levels and thermometer-code check (deb & (deb+1) is zero only for 0..01..1).
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    levelNext = '0;
    for (int i = 0; i < N_LEVELS; i++) levelNext = levelNext + 4'(deb[i]);
    fltNext = |(deb & (deb + SW_ONE));
  end

  // Level/fault register feeding the state machine.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      levelReg <= '0;
      flt      <= 1'b0;
    end else begin
      levelReg <= levelNext;
      flt      <= fltNext;
    end
  end

  // Free-running blink divider; the blink bit toggles on each wrap.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      blinkCnt <= '0;
      blinkBit <= 1'b0;
    end else if (blinkCnt == BLINK_LAST) begin
      blinkCnt <= '0;
      blinkBit <= ~blinkBit;
    end else begin
      blinkCnt <= blinkCnt + BW'(1);
    end
  end

  // State register together with the registered lamp/digit/level outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= NORMAL;
      Red      <= 1'b0;
      Green    <= 1'b1;
      Fault    <= 1'b0;
      Segments <= 7'b1000000;
      Level    <= '0;
    end else begin
      state    <= stateNext;
      Red      <= redNext;
      Green    <= greenNext;
      Fault    <= faultNext;
      Segments <= segNext;
      Level    <= levelReg;
    end
  end

  // Next-state logic: a fault overrides everything; ALARM has hysteresis between the thresholds.
  always_comb begin
    stateNext = state;
    if (flt) begin
      stateNext = FAULT;
    end else begin
      case (state)
        NORMAL:  if (levelReg >= HI_LEVEL) stateNext = ALARM;
        ALARM:   if (levelReg <= LO_LEVEL) stateNext = NORMAL;
        FAULT:   stateNext = (levelReg >= HI_LEVEL) ? ALARM : NORMAL;
        default: stateNext = NORMAL;
      endcase
    end
  end

  // Output decode from the next state so lamps and digit register in step with the state.
  always_comb begin
    redNext   = 1'b0;
    greenNext = 1'b0;
    faultNext = 1'b0;
    segNext   = segDecode(levelReg);
    case (stateNext)
      NORMAL: greenNext = 1'b1;
      ALARM:  redNext   = 1'b1;
      FAULT: begin
        redNext   = blinkBit;
        faultNext = 1'b1;
        segNext   = SEG_F;
      end
      default: greenNext = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_level_monitor.sv
// Directed bench for level_monitor: reset values, 8-edge latency, alarm
// hysteresis, glitch rejection, fault display with blink, async reset.
module tb_level_monitor;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b1;
  logic [5:0] Sw = '0;
  logic       Red, Green, Fault;
  logic [6:0] Segments;
  logic [3:0] Level;
  logic       clkEn = 1'b0;

  int checks = 0;
  int failures = 0;

  level_monitor #(
    .N_LEVELS  (6),
    .DEB_CYCLES(4),
    .HI_THRESH (6),
    .LO_THRESH (4),
    .BLINK_DIV (8)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Sw      (Sw),
    .Red     (Red),
    .Green   (Green),
    .Segments(Segments),
    .Level   (Level),
    .Fault   (Fault)
  );

  // Gated clock so reset can be tested with the clock stopped.
  initial forever begin
    #5;
    if (clkEn) Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic checkOut(input string tag, input logic r, input logic g, input logic f,
                          input logic [3:0] lv, input logic [6:0] seg);
    check({tag, ".red"}, Red, r);
    check({tag, ".green"}, Green, g);
    check({tag, ".fault"}, Fault, f);
    check({tag, ".level"}, Level, lv);
    check({tag, ".seg"}, Segments, seg);
  endtask

  initial begin
    int bad;
    int n;
    logic prev;

    // 1: reset with no clock running
    Sw = 6'b111111;
    #1 Rst_n = 1'b0;
    #2;
    checkOut("reset", 1'b0, 1'b1, 1'b0, 4'd0, 7'b1000000);

    // 2: release reset, Sw held all-ones -> ALARM exactly 8 edges later
    #2 Rst_n = 1'b1;
    #1 clkEn = 1'b1;
    tick(7);
    checkOut("lat_e7", 1'b0, 1'b1, 1'b0, 4'd0, 7'b1000000);
    tick();
    checkOut("lat_e8", 1'b1, 1'b0, 1'b0, 4'd6, 7'b0000010);

    // 3: hysteresis - level 5 stays in ALARM, level 4 returns to NORMAL
    Sw = 6'b011111;
    tick(8);
    checkOut("hyst5", 1'b1, 1'b0, 1'b0, 4'd5, 7'b0010010);
    Sw = 6'b001111;
    tick(8);
    checkOut("hyst4", 1'b0, 1'b1, 1'b0, 4'd4, 7'b0011001);

    // 4: a 3-cycle pulse is shorter than the debounce window and is ignored
    Sw = 6'b000000;
    tick(10);
    checkOut("empty", 1'b0, 1'b1, 1'b0, 4'd0, 7'b1000000);
    Sw = 6'b000001;
    tick(3);
    Sw = 6'b000000;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Level !== 4'd0 || Red !== 1'b0 || Green !== 1'b1 || Segments !== 7'b1000000) bad++;
    end
    check("pulse_filtered", bad, 0);

    // 5: non-thermometer pattern -> FAULT with blinking Red
    Sw = 6'b000101;
    tick(8);
    check("flt.fault", Fault, 1'b1);
    check("flt.green", Green, 1'b0);
    check("flt.seg", Segments, 7'b0001110);
    check("flt.level", Level, 4'd2);
    prev = Red;
    n = 0;
    while (n < 20 && Red === prev) begin
      tick();
      n++;
    end
    check("blink_seen", (Red !== prev), 1'b1);
    for (int p = 0; p < 2; p++) begin
      prev = Red;
      n = 0;
      do begin
        tick();
        n++;
      end while (Red === prev && n < 20);
      check("blink_period", n, 8);
    end
    check("flt.still", Fault, 1'b1);
    Sw = 6'b000111;
    tick(8);
    checkOut("flt_clear", 1'b0, 1'b1, 1'b0, 4'd3, 7'b0110000);

    // 6: async reset mid-cycle while in ALARM
    Sw = 6'b111111;
    tick(8);
    check("pre_rst.red", Red, 1'b1);
    #2 Rst_n = 1'b0;
    #1;
    checkOut("async_rst", 1'b0, 1'b1, 1'b0, 4'd0, 7'b1000000);
    #1 Rst_n = 1'b1;
    tick(7);
    check("rel_e7.red", Red, 1'b0);
    tick();
    checkOut("rel_e8", 1'b1, 1'b0, 1'b0, 4'd6, 7'b0000010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
